// File: rtl/robo_pkg.sv
// robo_pkg: shared types and screen constants for the robot movement slice.
// Contents: 9-bit coordinate type, screen limits and the mover state enum.
// Optional macro AXIS_SPLIT_EN adds the wall-sliding retry states.
package robo_pkg;
  localparam int X_MAX = 319;
  localparam int Y_MAX = 239;

  typedef logic [8:0] coord_t;

`ifdef AXIS_SPLIT_EN
  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, COMMIT, RETRY_X, RETRY_Y} state_t;
`else
  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, COMMIT} state_t;
`endif
endpackage

// File: rtl/character_mover_if.sv
// character_mover_if: probe handshake between the mover and the collision stage.
//   probe_x/probe_y : candidate top-left corner (mover -> collision)
//   probe_start     : one-cycle request pulse  (mover -> collision)
//   probe_done      : one-cycle result strobe  (collision -> mover)
//   probe_hit       : result, valid with probe_done
interface character_mover_if;
  import robo_pkg::*;

  coord_t probe_x;
  coord_t probe_y;
  logic   probe_start;
  logic   probe_done;
  logic   probe_hit;

  modport master (output probe_x, probe_y, probe_start, input probe_done, probe_hit);
  modport slave  (input probe_x, probe_y, probe_start, output probe_done, probe_hit);
endinterface

// File: rtl/move_candidate.sv
// move_candidate: combinational single-axis step with screen clamp.
//   pos   : current coordinate
//   dec   : request a step toward 0
//   inc   : request a step toward limit
//   limit : largest allowed coordinate (10-bit so the compare cannot wrap)
//   nxt   : candidate coordinate; equals pos when the step is cancelled
module move_candidate
  import robo_pkg::*;
#(
  parameter int STEP = 1
) (
  input  coord_t     pos,
  input  logic       dec,
  input  logic       inc,
  input  logic [9:0] limit,
  output coord_t     nxt
);
  logic [9:0] wide_pos;
  logic [9:0] wide_up;

  always_comb begin
    wide_pos = {1'b0, pos};
    wide_up  = wide_pos + 10'(STEP);
    nxt      = pos;
    if (dec && !inc) begin
      if (wide_pos >= 10'(STEP)) nxt = coord_t'(wide_pos - 10'(STEP));
    end else if (inc && !dec) begin
      if (wide_up <= limit) nxt = wide_up[8:0];
    end
  end
endmodule

// File: rtl/character_mover.sv
// character_mover: owns the committed sprite position. Each frame tick samples
// the direction keys, forms a clamped candidate, asks the collision stage via
// the probe handshake and commits or rejects the move.
//   clock, resetn       : clock, synchronous active-low reset
//   frame_tick          : one-cycle frame pulse (dropped while busy)
//   key_left..key_down  : direction requests
//   probe               : collision handshake (master side)
//   char_x, char_y      : committed position
//   busy                : high outside IDLE
//   move_done, moved    : end-of-tick pulse; moved=1 when the position changed
//   stuck_err           : sticky probe-timeout flag
// Optional macro AXIS_SPLIT_EN: a hit diagonal retries as X-only, then Y-only.
module character_mover
  import robo_pkg::*;
#(
  parameter int     X_MAX   = robo_pkg::X_MAX,
  parameter int     Y_MAX   = robo_pkg::Y_MAX,
  parameter int     CHAR_W  = 10,
  parameter int     CHAR_H  = 10,
  parameter int     STEP    = 1,
  parameter coord_t START_X = 9'd8,
  parameter coord_t START_Y = 9'd8,
  parameter int     TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_up,
  input  logic              key_down,
  character_mover_if.master probe,
  output coord_t            char_x,
  output coord_t            char_y,
  output logic              busy,
  output logic              move_done,
  output logic              moved,
  output logic              stuck_err
);
  localparam int         TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [9:0] X_LIM = 10'(X_MAX - CHAR_W + 1);
  localparam logic [9:0] Y_LIM = 10'(Y_MAX - CHAR_H + 1);

  state_t        state;
  logic          kl, kr, ku, kd;
  logic [TW-1:0] tcnt;
  coord_t        nx, ny;

  // Candidates stay valid for the whole transaction: keys are latched and
  // char_x/char_y only change on the COMMIT edge that ends it.
  move_candidate #(.STEP(STEP)) u_cand_x (
    .pos(char_x), .dec(kl), .inc(kr), .limit(X_LIM), .nxt(nx)
  );
  move_candidate #(.STEP(STEP)) u_cand_y (
    .pos(char_y), .dec(ku), .inc(kd), .limit(Y_LIM), .nxt(ny)
  );

`ifdef AXIS_SPLIT_EN
  logic diag;
  logic tried_x, tried_y;

  always_comb begin
    diag = (nx != char_x) && (ny != char_y);
  end
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state             <= IDLE;
      char_x            <= START_X;
      char_y            <= START_Y;
      probe.probe_x     <= START_X;
      probe.probe_y     <= START_Y;
      probe.probe_start <= 1'b0;
      busy              <= 1'b0;
      move_done         <= 1'b0;
      moved             <= 1'b0;
      stuck_err         <= 1'b0;
      tcnt              <= '0;
      {kl, kr, ku, kd}  <= '0;
`ifdef AXIS_SPLIT_EN
      tried_x           <= 1'b0;
      tried_y           <= 1'b0;
`endif
    end else begin
      probe.probe_start <= 1'b0;
      move_done         <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            {kl, kr, ku, kd} <= {key_left, key_right, key_up, key_down};
            busy             <= 1'b1;
            state            <= CALC;
          end
        end
        CALC: begin
`ifdef AXIS_SPLIT_EN
          tried_x <= 1'b0;
          tried_y <= 1'b0;
`endif
          if (nx == char_x && ny == char_y) begin
            move_done <= 1'b1;
            moved     <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            probe.probe_x     <= nx;
            probe.probe_y     <= ny;
            probe.probe_start <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (probe.probe_done) begin
            if (!probe.probe_hit) begin
              state <= COMMIT;
            end
`ifdef AXIS_SPLIT_EN
            else if (diag && !tried_x) begin
              tried_x <= 1'b1;
              state   <= RETRY_X;
            end else if (diag && !tried_y) begin
              tried_y <= 1'b1;
              state   <= RETRY_Y;
            end
`endif
            else begin
              move_done <= 1'b1;
              moved     <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            stuck_err <= 1'b1;
            move_done <= 1'b1;
            moved     <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        COMMIT: begin
          char_x    <= probe.probe_x;
          char_y    <= probe.probe_y;
          move_done <= 1'b1;
          moved     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
`ifdef AXIS_SPLIT_EN
        RETRY_X: begin
          probe.probe_x     <= nx;
          probe.probe_y     <= char_y;
          probe.probe_start <= 1'b1;
          state             <= REQ;
        end
        RETRY_Y: begin
          probe.probe_x     <= char_x;
          probe.probe_y     <= ny;
          probe.probe_start <= 1'b1;
          state             <= REQ;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_character_mover.sv
// tb_character_mover: directed bench for character_mover. A transaction-level
// model predicts the probe sequence and outcome of each tick from the movement
// rules; a compare process checks the DUT against it every cycle. Also builds
// with AXIS_SPLIT_EN defined.
module tb_character_mover;
  localparam int XL = 319 - 10 + 1;
  localparam int YL = 239 - 10 + 1;
`ifdef AXIS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {int x; int y;} pt_t;
  typedef struct {int x; int y; bit moved; bit stuck;} res_t;

  logic       clock = 1'b0;
  logic       resetn, frame_tick;
  logic       key_left, key_right, key_up, key_down;
  logic [8:0] char_x, char_y;
  logic       busy, move_done, moved, stuck_err;

  character_mover_if pif ();

  character_mover dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .probe(pif), .char_x(char_x), .char_y(char_y), .busy(busy),
    .move_done(move_done), .moved(moved), .stuck_err(stuck_err)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  int   mx = 8, my = 8;
  bit   ms = 0, mmoved = 0;
  pt_t  exp_probe[$];
  res_t exp_res[$];

  int   stub_lat = 1;
  bit   stub_mute = 0;
  bit   stub_hits[$];
  int   lp_x = -1, lp_y = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void next_pos(input int x, input int y, input bit l, input bit r,
                                   input bit u, input bit d, output int nx, output int ny);
    nx = x;
    ny = y;
    if (l && !r && x - 1 >= 0) nx = x - 1;
    if (r && !l && x + 1 <= XL) nx = x + 1;
    if (u && !d && y - 1 >= 0) ny = y - 1;
    if (d && !u && y + 1 <= YL) ny = y + 1;
  endfunction

  // Collision-stage stub: answers each probe_start after stub_lat cycles.
  initial begin : stub
    bit h;
    pif.probe_done = 1'b0;
    pif.probe_hit  = 1'b0;
    forever begin
      @(negedge clock);
      if (pif.probe_start === 1'b1) begin
        lp_x = int'(pif.probe_x);
        lp_y = int'(pif.probe_y);
        if (!stub_mute) begin
          h = 1'b0;
          if (stub_hits.size() > 0) h = stub_hits.pop_front();
          repeat (stub_lat) @(negedge clock);
          pif.probe_done = 1'b1;
          pif.probe_hit  = h;
          @(negedge clock);
          pif.probe_done = 1'b0;
          pif.probe_hit  = 1'b0;
        end
      end
    end
  end

  // Compare process: checks probes, results and committed state every cycle.
  initial begin : cmp
    bit   rst_q;
    bit   armed;
    pt_t  p;
    res_t e;
    armed = 1'b0;
    forever begin
      @(posedge clock);
      rst_q = !resetn;
      @(negedge clock);
      if (rst_q) begin
        mx = 8; my = 8; ms = 1'b0; mmoved = 1'b0;
        exp_probe.delete();
        exp_res.delete();
        armed = 1'b1;
      end
      if (armed) begin
        if (pif.probe_start === 1'b1) begin
          if (exp_probe.size() == 0) begin
            check("unexpected_probe_start", 1, 0);
          end else begin
            p = exp_probe.pop_front();
            check("probe_x", pif.probe_x, p.x);
            check("probe_y", pif.probe_y, p.y);
          end
        end
        if (move_done === 1'b1) begin
          if (exp_res.size() == 0) begin
            check("unexpected_move_done", 1, 0);
          end else begin
            e = exp_res.pop_front();
            mx = e.x; my = e.y; ms = e.stuck; mmoved = e.moved;
          end
        end
        check("char_x", char_x, mx);
        check("char_y", char_y, my);
        check("stuck_err", stuck_err, ms);
        check("moved", moved, mmoved);
      end
    end
  end

  task automatic run_tick(input bit l, input bit r, input bit u, input bit d, input int lat,
                          input bit h0, input bit h1, input bit h2, input bit mute,
                          input int extra_at, output int n);
    int   cx, cy;
    bit   diag;
    pt_t  p;
    res_t e;
    @(negedge clock);
    next_pos(mx, my, l, r, u, d, cx, cy);
    diag = (cx != mx) && (cy != my);
    e.x = mx; e.y = my; e.moved = 1'b0; e.stuck = ms;
    if (cx != mx || cy != my) begin
      p.x = cx; p.y = cy; exp_probe.push_back(p);
      if (mute) begin
        e.stuck = 1'b1;
      end else if (!h0) begin
        e.x = cx; e.y = cy; e.moved = 1'b1;
      end else if (SPLIT && diag) begin
        p.x = cx; p.y = my; exp_probe.push_back(p);
        if (!h1) begin
          e.x = cx; e.moved = 1'b1;
        end else begin
          p.x = mx; p.y = cy; exp_probe.push_back(p);
          if (!h2) begin
            e.y = cy; e.moved = 1'b1;
          end
        end
      end
    end
    exp_res.push_back(e);
    stub_hits = '{h0, h1, h2};
    stub_lat  = lat;
    stub_mute = mute;
    key_left = l; key_right = r; key_up = u; key_down = d;
    frame_tick = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      frame_tick = (n == extra_at);
      key_left = 0; key_right = 0; key_up = 0; key_down = 0;
    end while (move_done !== 1'b1 && n < 200);
    frame_tick = 1'b0;
    check("move_done_seen", move_done, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  n;
    int  cx, cy;
    pt_t p;
    resetn = 1'b0; frame_tick = 1'b0;
    key_left = 0; key_right = 0; key_up = 0; key_down = 0;
    repeat (3) @(negedge clock);
    check("rst_char_x", char_x, 8);
    check("rst_char_y", char_y, 8);
    check("rst_probe_x", pif.probe_x, 8);
    check("rst_probe_y", pif.probe_y, 8);
    check("rst_probe_start", pif.probe_start, 0);
    check("rst_busy", busy, 0);
    check("rst_move_done", move_done, 0);
    check("rst_moved", moved, 0);
    check("rst_stuck", stuck_err, 0);
    resetn = 1'b1;

    // Right step, probe latency 3: commit after 7 cycles.
    run_tick(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, n);
    check("t1_latency", n, 7);
    check("t1_probe_x", lp_x, 9);
    check("t1_probe_y", lp_y, 8);
    check("t1_char_x", char_x, 9);
    check("t1_moved", moved, 1);

    // Opposing horizontal keys cancel; down still moves.
    do_reset();
    run_tick(1, 1, 0, 1, 2, 0, 0, 0, 0, 0, n);
    check("t3_probe_x", lp_x, 8);
    check("t3_probe_y", lp_y, 9);
    check("t3_latency", n, 6);

    // Up with a hit: rejected.
    run_tick(0, 0, 1, 0, 2, 1, 0, 0, 0, 0, n);
    check("t4_latency", n, 5);
    check("t4_char_y", char_y, 9);
    check("t4_moved", moved, 0);

    // Silent collision stage: timeout after 64 WAIT cycles.
    run_tick(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, n);
    check("t5_latency", n, 67);
    check("t5_stuck", stuck_err, 1);
    check("t5_busy", busy, 0);
    check("t5_char_x", char_x, 8);
    run_tick(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, n);
    check("t5b_char_y", char_y, 8);
    check("t5b_stuck_sticky", stuck_err, 1);

    // Second frame_tick during WAIT is dropped.
    run_tick(0, 1, 0, 0, 5, 0, 0, 0, 0, 4, n);
    check("t6_latency", n, 9);
    check("t6_char_x", char_x, 9);
    repeat (20) @(negedge clock);
    check("t6_busy_idle", busy, 0);

    // Reset in the middle of WAIT.
    @(negedge clock);
    next_pos(mx, my, 0, 0, 0, 1, cx, cy);
    p.x = cx; p.y = cy; exp_probe.push_back(p);
    stub_mute = 1'b1;
    key_down = 1'b1;
    frame_tick = 1'b1;
    repeat (6) begin
      @(negedge clock);
      frame_tick = 1'b0;
      key_down = 1'b0;
    end
    check("t7_busy_wait", busy, 1);
    resetn = 1'b0;
    @(negedge clock);
    check("t7_char_x", char_x, 8);
    check("t7_char_y", char_y, 8);
    check("t7_busy", busy, 0);
    check("t7_stuck", stuck_err, 0);
    check("t7_move_done", move_done, 0);
    resetn = 1'b1;
    stub_mute = 1'b0;
    repeat (5) @(negedge clock);

    // Top-left and right-edge clamps.
    for (int i = 0; i < 8; i++) run_tick(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, n);
    check("t8_corner_x", char_x, 0);
    check("t8_corner_y", char_y, 0);
    run_tick(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, n);
    check("t8_corner_latency", n, 2);
    for (int i = 0; i < 310; i++) run_tick(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, n);
    check("t8_edge_x", char_x, 310);
    run_tick(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, n);
    check("t8_edge_latency", n, 2);
    check("t8_edge_moved", moved, 0);
    check("t8_edge_hold_x", char_x, 310);
    run_tick(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, n);
    check("t8_slide_probe_x", lp_x, 310);
    check("t8_slide_probe_y", lp_y, 1);

    // Diagonal hit handling at (20,20).
    do_reset();
    for (int i = 0; i < 12; i++) run_tick(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, n);
    check("t9_start_x", char_x, 20);
    check("t9_start_y", char_y, 20);
    run_tick(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, n);
`ifdef AXIS_SPLIT_EN
    check("t9_probe_x", lp_x, 21);
    check("t9_probe_y", lp_y, 20);
    check("t9_char_x", char_x, 21);
    check("t9_char_y", char_y, 20);
    check("t9_moved", moved, 1);
`else
    check("t9_probe_x", lp_x, 21);
    check("t9_probe_y", lp_y, 19);
    check("t9_char_x", char_x, 20);
    check("t9_moved", moved, 0);
`endif
    run_tick(0, 1, 1, 0, 1, 1, 1, 1, 0, 0, n);
    check("t9b_last_probe_x", lp_x, 21);
    check("t9b_last_probe_y", lp_y, 19);
    check("t9b_moved", moved, 0);
    repeat (10) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
